// File: rtl/pipeline_perf_monitor_if.sv
// Connection between the datapath debug outputs and the performance monitor.
// Contract: no valid/ready pair; every clock in RUN is one sample, there is no backpressure.
interface pipeline_perf_monitor_if #(
    parameter int CNT_W = 32
);
    logic             clear;
    logic [31:0]      pc_in;
    logic [31:0]      instr_in;
    logic             stall_in;
    logic             branch_in;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] branch_count;
    logic             halted;
    logic [31:0]      halt_pc;
    logic [2:0]       halt_period;
    logic             state_dbg;

    modport master (
        output clear, pc_in, instr_in, stall_in, branch_in,
        input  cycle_count, instr_count, stall_count, branch_count,
        input  halted, halt_pc, halt_period, state_dbg
    );

    modport slave (
        input  clear, pc_in, instr_in, stall_in, branch_in,
        output cycle_count, instr_count, stall_count, branch_count,
        output halted, halt_pc, halt_period, state_dbg
    );
endinterface

// File: rtl/pipeline_perf_monitor.sv
// Event counters for a datapath plus a halt-loop detector (periods 1..4) that
// freezes the statistics once the program spins on a fixed PC pattern.
module pipeline_perf_monitor #(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          THR_P1    = 3,
    parameter int          THR_P2    = 4,
    parameter int          THR_P3    = 6,
    parameter int          THR_P4    = 8
) (
    input logic                     clock,
    input logic                     reset,
    pipeline_perf_monitor_if.slave  bus
);
    localparam int MW = 4;
    localparam logic [MW-1:0] THR_V [4] = '{MW'(THR_P1), MW'(THR_P2), MW'(THR_P3), MW'(THR_P4)};

    typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] branch_q, branch_d;
    logic [31:0]      hist_q [4];
    logic [31:0]      hist_d [4];
    logic [31:0]      prev_instr_q, prev_instr_d;
    logic [2:0]       valid_q, valid_d;
    logic [MW-1:0]    m_q [4];
    logic [MW-1:0]    m_d [4];
    logic [MW-1:0]    m_nx [4];
    logic [31:0]      halt_pc_q, halt_pc_d;
    logic [2:0]       period_q, period_d;
    logic [3:0]       hit;
    logic [3:0]       trig;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        instr_d      = instr_q;
        stall_d      = stall_q;
        branch_d     = branch_q;
        hist_d       = hist_q;
        prev_instr_d = prev_instr_q;
        valid_d      = valid_q;
        m_d          = m_q;
        halt_pc_d    = halt_pc_q;
        period_d     = period_q;
        hit          = '0;
        trig         = '0;
        for (int k = 0; k < 4; k++) begin
            m_nx[k] = '0;
        end

        // Period-1 also requires the same instruction, so a stalled PC alone is not a loop.
        hit[0] = (valid_q >= 3'd1) && (bus.pc_in == hist_q[0]) && (bus.instr_in == prev_instr_q);
        for (int k = 1; k < 4; k++) begin
            hit[k] = (valid_q >= 3'(k + 1)) && (bus.pc_in == hist_q[k]);
        end
        for (int k = 0; k < 4; k++) begin
            if (hit[k]) begin
                m_nx[k] = (m_q[k] == THR_V[k]) ? m_q[k] : m_q[k] + 1'b1;
            end
            trig[k] = hit[k] && (m_nx[k] == THR_V[k]);
        end

        if (state_q == ST_RUN) begin
            cycle_d      = sat_inc(cycle_q, 1'b1);
            instr_d      = sat_inc(instr_q, (bus.instr_in != NOP_INSTR) && !bus.stall_in);
            stall_d      = sat_inc(stall_q, bus.stall_in);
            branch_d     = sat_inc(branch_q, bus.branch_in);
            hist_d[0]    = bus.pc_in;
            hist_d[1]    = hist_q[0];
            hist_d[2]    = hist_q[1];
            hist_d[3]    = hist_q[2];
            prev_instr_d = bus.instr_in;
            valid_d      = (valid_q == 3'd4) ? valid_q : valid_q + 3'd1;
            m_d          = m_nx;
            // The triggering sample is still counted; the freeze starts on the next cycle.
            if (|trig) begin
                state_d   = ST_HALTED;
                halt_pc_d = bus.pc_in;
                if (trig[0])      period_d = 3'd1;
                else if (trig[1]) period_d = 3'd2;
                else if (trig[2]) period_d = 3'd3;
                else              period_d = 3'd4;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || bus.clear) begin
            state_q      <= ST_RUN;
            cycle_q      <= '0;
            instr_q      <= '0;
            stall_q      <= '0;
            branch_q     <= '0;
            prev_instr_q <= '0;
            valid_q      <= '0;
            halt_pc_q    <= '0;
            period_q     <= '0;
            for (int k = 0; k < 4; k++) begin
                hist_q[k] <= '0;
                m_q[k]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            instr_q      <= instr_d;
            stall_q      <= stall_d;
            branch_q     <= branch_d;
            prev_instr_q <= prev_instr_d;
            valid_q      <= valid_d;
            halt_pc_q    <= halt_pc_d;
            period_q     <= period_d;
            for (int k = 0; k < 4; k++) begin
                hist_q[k] <= hist_d[k];
                m_q[k]    <= m_d[k];
            end
        end
    end

    assign bus.cycle_count  = cycle_q;
    assign bus.instr_count  = instr_q;
    assign bus.stall_count  = stall_q;
    assign bus.branch_count = branch_q;
    assign bus.halted       = (state_q == ST_HALTED);
    assign bus.halt_pc      = halt_pc_q;
    assign bus.halt_period  = period_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed bench for pipeline_perf_monitor: a 32-bit counter instance and a 4-bit
// counter instance share the same stimulus; expected snapshots go through a queue.
module tb_pipeline_perf_monitor;
    localparam int EXP_W = 1 + 3 + 32 + 4 * 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        stall_r;
    logic        branch_r;
    int          cyc = 0;

    logic [EXP_W-1:0] exp_q[$];
    int               at_q[$];
    bit               sel_q[$];
    string            name_q[$];
    int               n_cmp = 0;
    int               n_fail = 0;

    pipeline_perf_monitor_if #(.CNT_W(32)) bus  ();
    pipeline_perf_monitor_if #(.CNT_W(4))  bus4 ();

    assign bus.clear      = clear_r;
    assign bus.pc_in      = pc_r;
    assign bus.instr_in   = instr_r;
    assign bus.stall_in   = stall_r;
    assign bus.branch_in  = branch_r;
    assign bus4.clear     = clear_r;
    assign bus4.pc_in     = pc_r;
    assign bus4.instr_in  = instr_r;
    assign bus4.stall_in  = stall_r;
    assign bus4.branch_in = branch_r;

    pipeline_perf_monitor #(.CNT_W(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    pipeline_perf_monitor #(.CNT_W(4)) dut4 (
        .clock (clk),
        .reset (rst),
        .bus   (bus4.slave)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // driver tasks
    task automatic step(input logic [31:0] pc, input logic [31:0] instr, input logic st, input logic br);
        pc_r     = pc;
        instr_r  = instr;
        stall_r  = st;
        branch_r = br;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input bit sel, input logic h, input logic [2:0] per,
                              input logic [31:0] hpc, input logic [31:0] c, input logic [31:0] i,
                              input logic [31:0] s, input logic [31:0] b);
        exp_q.push_back({h, per, hpc, c, i, s, b});
        at_q.push_back(cyc);
        sel_q.push_back(sel);
        name_q.push_back(nm);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EXP_W-1:0] act;
        logic [EXP_W-1:0] e;
        bit               sel;
        string            nm;
        while (at_q.size() > 0 && at_q[0] <= cyc) begin
            void'(at_q.pop_front());
            e   = exp_q.pop_front();
            sel = sel_q.pop_front();
            nm  = name_q.pop_front();
            if (sel)
                act = {bus4.halted, bus4.halt_period, bus4.halt_pc, 32'(bus4.cycle_count),
                       32'(bus4.instr_count), 32'(bus4.stall_count), 32'(bus4.branch_count)};
            else
                act = {bus.halted, bus.halt_period, bus.halt_pc, bus.cycle_count,
                       bus.instr_count, bus.stall_count, bus.branch_count};
            n_cmp++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s (dut%0d): got h=%0b per=%0d pc=%h cyc=%0d ins=%0d stl=%0d br=%0d, need h=%0b per=%0d pc=%h cyc=%0d ins=%0d stl=%0d br=%0d",
                         nm, sel ? 4 : 32, act[163], act[162:160], act[159:128], act[127:96], act[95:64], act[63:32], act[31:0],
                         e[163], e[162:160], e[159:128], e[127:96], e[95:64], e[63:32], e[31:0]);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        clear_r  = 1'b0;
        pc_r     = '0;
        instr_r  = '0;
        stall_r  = 1'b0;
        branch_r = 1'b0;

        repeat (3) begin
            pc_r     = $urandom;
            instr_r  = $urandom;
            stall_r  = 1'($urandom_range(0, 1));
            branch_r = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // period-1 loop: PCs 0x04..0x28, then 0x28/0x6F repeated
        for (int i = 1; i <= 10; i++)
            step(32'(4 * i), (i == 10) ? 32'h6F : 32'h100 + 32'(i), 1'b0, 1'b0);
        step(32'h28, 32'h6F, 1'b0, 1'b0);
        step(32'h28, 32'h6F, 1'b0, 1'b0);
        expect_out("p1_pre", 0, 0, 0, 0, 12, 12, 0, 0);
        step(32'h28, 32'h6F, 1'b0, 1'b0);
        expect_out("p1_halt", 0, 1, 1, 32'h28, 13, 13, 0, 0);
        step(32'h200, 32'h1234, 1'b1, 1'b1);
        step(32'h204, 32'h1235, 1'b0, 1'b1);
        expect_out("p1_frozen", 0, 1, 1, 32'h28, 13, 13, 0, 0);

        clear_r = 1'b1;
        step(32'h300, 32'h77, 1'b1, 1'b1);
        clear_r = 1'b0;
        expect_out("clear", 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("clear", 1, 0, 0, 0, 0, 0, 0, 0);

        // period-2 loop
        for (int i = 0; i < 5; i++)
            step((i % 2 == 1) ? 32'h44 : 32'h40, 32'h33, 1'b0, 1'b0);
        expect_out("p2_pre", 0, 0, 0, 0, 5, 5, 0, 0);
        step(32'h44, 32'h33, 1'b0, 1'b0);
        expect_out("p2_halt", 0, 1, 2, 32'h44, 6, 6, 0, 0);
        clear_r = 1'b1;
        step(32'h0, 32'h0, 1'b0, 1'b0);
        clear_r = 1'b0;

        // period-4 loop with stalls at samples 2,6 and branches at 1,5,9
        for (int i = 0; i < 11; i++)
            step(32'h10 + 32'(4 * (i % 4)), 32'h500 + 32'(i), (i == 2) || (i == 6),
                 (i == 1) || (i == 5) || (i == 9));
        expect_out("p4_pre", 0, 0, 0, 0, 11, 9, 2, 3);
        step(32'h1C, 32'h50B, 1'b0, 1'b0);
        expect_out("p4_halt", 0, 1, 4, 32'h1C, 12, 10, 2, 3);
        clear_r = 1'b1;
        step(32'h0, 32'h0, 1'b0, 1'b0);
        clear_r = 1'b0;

        // NOP exclusion and saturation of the 4-bit instance
        for (int i = 0; i < 22; i++) begin
            step(32'h1000 + 32'(4 * i), (i >= 12 && i <= 16) ? 32'h13 : 32'h900 + 32'(i), 1'b0, 1'b0);
            if (i == 11) begin
                expect_out("run12", 0, 0, 0, 0, 12, 12, 0, 0);
                expect_out("run12", 1, 0, 0, 0, 12, 12, 0, 0);
            end
            if (i == 16) begin
                expect_out("nop5", 0, 0, 0, 0, 17, 12, 0, 0);
                expect_out("nop5", 1, 0, 0, 0, 15, 12, 0, 0);
            end
            if (i == 19) begin
                expect_out("sat_reach", 0, 0, 0, 0, 20, 15, 0, 0);
                expect_out("sat_reach", 1, 0, 0, 0, 15, 15, 0, 0);
            end
            if (i == 21) begin
                expect_out("sat_hold", 0, 0, 0, 0, 22, 17, 0, 0);
                expect_out("sat_hold", 1, 0, 0, 0, 15, 15, 0, 0);
            end
        end

        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (at_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, need 0", at_q.size());
        end

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
